psum_result_streamer: RTL and testbench
=======================================

// Module: psum_result_streamer
// PURPOSE
//  Downstream stage of the 9/3/1-to-1 adder tree. Captures one registered 288b
//  result vector (72 x 4b) plus its accumulation mode, then streams only the
//  mode-valid nibbles to the activation buffer as 32b words (8 x 4b) over a
//  valid/ready interface. Decouples adder-tree timing from buffer backpressure.
// PARAMETERS
//  RES_W    288  width of result vector from adder tree (72 lanes x 4b)
//  WORD_W   32   output word width (8 lanes x 4b); RES_W must be 9*WORD_W
//  FCNT_W   16   width of completed-frame counter
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       in_res/in_mode valid this cycle
//  in_ready   out  1       streamer can accept a frame this cycle
//  in_res     in   RES_W   result vector; word k = in_res[32k+31:32k]
//  in_mode    in   2       0: 9-to-1, 1: 3-to-1, 2: 1-to-1, 3: illegal
//  out_valid  out  1       out_data holds a valid word
//  out_ready  in   1       downstream accepts word this cycle
//  out_data   out  WORD_W  current word
//  out_idx    out  4       word index within frame (0..8)
//  out_last   out  1       current word is last word of frame
//  err_mode   out  1       sticky: an in_mode==3 frame was accepted
//  frame_cnt  out  FCNT_W  count of fully drained frames, wraps at 2^FCNT_W
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, out_data=0, out_idx=0, out_last=0,
//   err_mode=0, frame_cnt=0, hold register=0; in_ready=1 after reset release.
//  Words per frame NW: mode0=1 (res[31:0]), mode1=3 (res[95:0]),
//   mode2=9 (res[287:0]). Words emitted in ascending k; nibble order untouched.
//  FSM states IDLE, DRAIN.
//  IDLE: in_ready=1, out_valid=0. On in_valid: latch in_res into hold,
//   NW from in_mode, cnt=0; legal mode -> DRAIN (out_valid=1 next cycle,
//   1-cycle input-to-output latency); mode3 -> stay IDLE, set err_mode, no output.
//  DRAIN: out_valid=1, out_data=hold[32*cnt +: 32], out_idx=cnt,
//   out_last=(cnt==NW-1). out_data/out_idx/out_last held stable while
//   out_valid && !out_ready. Handshake = out_valid && out_ready.
//   Handshake, not last: cnt+1. Handshake on last: frame_cnt+1, then
//   if in_valid in same cycle -> accept new frame (back-to-back, no bubble),
//   legal mode stays DRAIN with cnt=0, mode3 -> IDLE + err_mode; else -> IDLE.
//  in_ready = IDLE | (DRAIN & out_last & out_ready) (comb path out_ready->in_ready
//   is intentional; no path from in_valid to out_valid in same cycle).
//  in_valid while in_ready=0: ignored, not stored; upstream must hold.
//  in_mode changes mid-frame have no effect; NW fixed at acceptance.
//  frame_cnt wraps all-ones -> 0. err_mode clears only on rst_n.
//  Reset asserted mid-frame: in-flight words discarded, all outputs to reset values.
// STRUCTURE
//  Shared package: MODE_9TO1/MODE_3TO1/MODE_1TO1/MODE_ILLEGAL constants,
//   NIB_W=4, LANES=8, words_per_mode() function (0->1, 1->3, 2->9, 3->0);
//   same package used by the adder tree mode decode.
//  One sub-module natural: psum_word_mux (hold register + cnt -> 32b word
//   select, purely combinational); FSM, counters and handshake stay in top.
// TESTING
//  1 mode0, res[31:0]=0x8765_4321, out_ready=1 -> one word 0x87654321,
//    idx0, last=1, 1 cycle after accept; frame_cnt=1.
//  2 mode2, word k = {8{k[3:0]}}, out_ready=1 -> 9 words 0x00000000..0x88888888
//    on consecutive cycles, last only on idx8; next frame accepted same cycle.
//  3 mode1 with out_ready toggling 1,0,0,1,... -> 3 words, data/idx stable
//    while stalled, no duplicates/drops, in_ready=0 until last handshake.
//  4 mode3 frame then mode0 frame -> no output for first, err_mode=1 sticky,
//    second frame streams normally, frame_cnt=1.
//  5 rst_n low after idx4 of mode2 frame -> outputs zero asynchronously;
//    after release in_ready=1, new mode0 frame streams with idx0.
//  6 frame_cnt preloaded via 65535 mode0 frames -> 65536th wraps to 0.

Source files
------------

// File: rtl/psum_result_streamer_pkg.sv
// Mode constants and word-count decode shared by the adder tree and the result streamer.
// No logic here: constants, the FSM state type and the mode-to-words helper.
package psum_result_streamer_pkg;

  localparam int NIB_W     = 4;
  localparam int LANES     = 8;
  localparam int MAX_WORDS = 9;
  localparam int IDX_W     = 4;

  localparam logic [1:0] MODE_9TO1    = 2'd0;
  localparam logic [1:0] MODE_3TO1    = 2'd1;
  localparam logic [1:0] MODE_1TO1    = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  function automatic logic [IDX_W-1:0] words_per_mode(input logic [1:0] mode);
    case (mode)
      MODE_9TO1: return IDX_W'(1);
      MODE_3TO1: return IDX_W'(3);
      MODE_1TO1: return IDX_W'(9);
      default:   return IDX_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/psum_word_mux.sv
// Selects word `sel` out of the held result vector; purely combinational.
// Zero latency, no backpressure; an out-of-range select yields zero.
module psum_word_mux
  import psum_result_streamer_pkg::*;
#(
  parameter int RES_W  = 288,
  parameter int WORD_W = 32
) (
  input  logic [RES_W-1:0]  hold,
  input  logic [IDX_W-1:0]  sel,
  output logic [WORD_W-1:0] word
);

  localparam int NWORDS = RES_W / WORD_W;

  always_comb begin
    word = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (sel == IDX_W'(k)) word = hold[k*WORD_W +: WORD_W];
    end
  end

endmodule

// File: rtl/psum_result_streamer.sv
// Captures one adder-tree result frame and streams its mode-valid words; 1 cycle accept-to-output.
// Output held stable under out_ready=0; in_ready only in IDLE or on the last word's handshake.
module psum_result_streamer
  import psum_result_streamer_pkg::*;
#(
  parameter int RES_W  = 288,
  parameter int WORD_W = 32,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RES_W-1:0]  in_res,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              err_mode,
  output logic [FCNT_W-1:0] frame_cnt
);

  state_e             state_q, state_d;
  logic [RES_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]   nw_q, nw_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic               hs;
  logic               accept;
  logic [WORD_W-1:0]  word;

  psum_word_mux #(
    .RES_W  (RES_W),
    .WORD_W (WORD_W)
  ) u_word_mux (
    .hold (hold_q),
    .sel  (cnt_q),
    .word (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      nw_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      nw_q    <= nw_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    nw_d      = nw_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    fcnt_d    = fcnt_q;
    out_valid = (state_q == ST_DRAIN);
    out_last  = out_valid && (cnt_q == (nw_q - IDX_W'(1)));
    hs        = out_valid && out_ready;
    // Ready opens on the last handshake so a waiting frame follows with no bubble.
    in_ready  = (state_q == ST_IDLE) || (hs && out_last);
    accept    = in_valid && in_ready;

    if (hs) begin
      if (out_last) begin
        fcnt_d  = fcnt_q + FCNT_W'(1);
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + IDX_W'(1);
      end
    end

    // Acceptance overrides the drain update above for back-to-back frames.
    if (accept) begin
      hold_d = in_res;
      nw_d   = words_per_mode(in_mode);
      cnt_d  = '0;
      if (in_mode == MODE_ILLEGAL) err_d = 1'b1;
      else                         state_d = ST_DRAIN;
    end
  end

  assign out_data  = out_valid ? word : '0;
  assign out_idx   = cnt_q;
  assign err_mode  = err_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_psum_result_streamer.sv
// Bench for psum_result_streamer: per-frame vector table, reset/wrap sequences, random traffic
// checked cycle by cycle against a queue-of-expected-words model.
module tb_psum_result_streamer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [287:0] in_res;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [3:0]   out_idx;
  logic         out_last;
  logic         err_mode;
  logic [15:0]  frame_cnt;

  always #5 clk = ~clk;

  psum_result_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_res    (in_res),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .err_mode  (err_mode),
    .frame_cnt (frame_cnt)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } word_t;

  typedef struct {
    logic [1:0]   mode;
    logic [287:0] res;
    logic [3:0]   rdy_pat;
    int           exp_nw;
    logic [31:0]  exp_last;
  } vec_t;

  word_t       exp_q[$];
  logic        m_err;
  logic [15:0] m_fcnt;
  logic        accepted;
  int          words_seen;
  logic [31:0] last_data;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nw_of(input logic [1:0] m);
    case (m)
      2'd0:    return 1;
      2'd1:    return 3;
      2'd2:    return 9;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_err  = 1'b0;
    m_fcnt = '0;
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic cyc(input logic v, input logic [1:0] m, input logic [287:0] r, input logic ordy);
    logic  exp_rdy;
    word_t e;
    @(negedge clk);
    in_valid  = v;
    in_mode   = m;
    in_res    = r;
    out_ready = ordy;
    #1;
    exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("out_data", 64'(out_data), 64'(exp_q[0].data));
      chk("out_idx",  64'(out_idx),  64'(exp_q[0].idx));
      chk("out_last", 64'(out_last), 64'(exp_q[0].last));
    end
    chk("in_ready",  64'(in_ready),  64'(exp_rdy));
    chk("err_mode",  64'(err_mode),  64'(m_err));
    chk("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
    if (exp_q.size() != 0 && ordy) begin
      e = exp_q.pop_front();
      words_seen++;
      last_data = out_data;
      if (e.last) m_fcnt++;
    end
    if (v && exp_rdy) begin
      accepted = 1'b1;
      if (m == 2'd3) m_err = 1'b1;
      for (int k = 0; k < nw_of(m); k++) begin
        e.data = r[32*k +: 32];
        e.idx  = 4'(k);
        e.last = (k == nw_of(m) - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_frame(input logic [1:0] m, input logic [287:0] r, input logic [3:0] pat);
    int c;
    c = 0;
    accepted = 1'b0;
    while (!accepted && c < 20) begin
      cyc(1'b1, m, r, pat[c % 4]);
      c++;
    end
    while (exp_q.size() != 0 && c < 80) begin
      cyc(1'b0, m, r, pat[c % 4]);
      c++;
    end
    n_tests++;
    if (!accepted || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL frame_timeout: accepted=%0d pending=%0d required accepted=1 pending=0",
               accepted, exp_q.size());
    end
  endtask

  function automatic logic [287:0] rand_res();
    logic [287:0] r;
    for (int k = 0; k < 9; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  vec_t         tab[5];
  logic [287:0] r;

  initial begin
    // Vector table: 9-to-1, 1-to-1 ramp, 3-to-1 with stalls, illegal, then a normal frame.
    r = rand_res();
    r[31:0] = 32'h8765_4321;
    tab[0] = '{mode: 2'd0, res: r, rdy_pat: 4'b1111, exp_nw: 1, exp_last: 32'h8765_4321};
    for (int k = 0; k < 9; k++) r[32*k +: 32] = {8{4'(k)}};
    tab[1] = '{mode: 2'd2, res: r, rdy_pat: 4'b1111, exp_nw: 9, exp_last: 32'h8888_8888};
    r = rand_res();
    r[95:0] = {32'hC0DE_0003, 32'hB0B0_0002, 32'hA5A5_0001};
    tab[2] = '{mode: 2'd1, res: r, rdy_pat: 4'b1001, exp_nw: 3, exp_last: 32'hC0DE_0003};
    r = rand_res();
    tab[3] = '{mode: 2'd3, res: r, rdy_pat: 4'b1111, exp_nw: 0, exp_last: 32'h0};
    r = rand_res();
    r[31:0] = 32'h0F1E_2D3C;
    tab[4] = '{mode: 2'd0, res: r, rdy_pat: 4'b1111, exp_nw: 1, exp_last: 32'h0F1E_2D3C};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 2'd0;
    in_res    = '0;
    out_ready = 1'b0;
    model_reset();
    words_seen = 0;
    last_data  = '0;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_idx",   64'(out_idx),   64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_err_mode",  64'(err_mode),  64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tab[i]) begin
      words_seen = 0;
      send_frame(tab[i].mode, tab[i].res, tab[i].rdy_pat);
      chk($sformatf("vec%0d_words", i), 64'(words_seen), 64'(tab[i].exp_nw));
      if (tab[i].exp_nw > 0)
        chk($sformatf("vec%0d_last_data", i), 64'(last_data), 64'(tab[i].exp_last));
    end
    cyc(1'b0, 2'd0, '0, 1'b1);
    chk("vec_err_sticky", 64'(err_mode), 64'd1);
    chk("vec_frame_cnt",  64'(frame_cnt), 64'd4);

    // Reset in the middle of a 1-to-1 frame, once idx4 is on the bus.
    words_seen = 0;
    for (int k = 0; k < 9; k++) r[32*k +: 32] = 32'h1000_0000 * (k + 1);
    cyc(1'b1, 2'd2, r, 1'b1);
    while (words_seen < 4) cyc(1'b0, 2'd2, r, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data",  64'(out_data),  64'd0);
    chk("midrst_out_idx",   64'(out_idx),   64'd0);
    chk("midrst_err_mode",  64'(err_mode),  64'd0);
    chk("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_in_ready", 64'(in_ready), 64'd1);
    words_seen = 0;
    r = rand_res();
    r[31:0] = 32'h5A5A_1234;
    send_frame(2'd0, r, 4'b1111);
    chk("postrst_last_data", 64'(last_data), 64'h5A5A_1234);

    // Randomized traffic with back-to-back frames, stalls and illegal modes.
    for (int n = 0; n < 2000; n++)
      cyc(($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), rand_res(),
          ($urandom_range(0, 3) != 0));
    while (exp_q.size() != 0) cyc(1'b0, 2'd0, '0, 1'b1);

    // Counter wrap: 65536 back-to-back single-word frames from reset.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 65536; n++) begin
      r[31:0] = 32'(n);
      cyc(1'b1, 2'd0, r, 1'b1);
      if (n == 65535) chk("wrap_pre_cnt", 64'(frame_cnt), 64'hFFFE);
    end
    cyc(1'b0, 2'd0, '0, 1'b1);
    chk("wrap_all_ones", 64'(frame_cnt), 64'hFFFF);
    cyc(1'b0, 2'd0, '0, 1'b1);
    chk("wrap_to_zero", 64'(frame_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
